// File: rtl/lockin_demodulator.sv
// Multi-channel lock-in demodulator: one time-shared signed multiplier accumulates
// sig*sin and sig*cos per channel, then dumps the window mean every 2^DECIM_LOG2 ticks.
//
// state | meaning
// IDLE  | waiting for a tick; inputs are latched when one is accepted
// MAC   | 2*NUM_CH multiply-accumulate cycles, ch k/2 x (sin if k even, cos if k odd)
// DUMP  | window complete: publish acc >>> DECIM_LOG2, clear accumulators, pulse valid_o
module lockin_demodulator #(
    parameter int NUM_BITS   = 24,
    parameter int NUM_CH     = 4,
    parameter int DECIM_LOG2 = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         tick_i,
    input  logic                         clear_i,
    input  logic [NUM_CH*NUM_BITS-1:0]   sig_i,
    input  logic [NUM_BITS-1:0]          sin_i,
    input  logic [NUM_BITS-1:0]          cos_i,
    output logic [NUM_CH*2*NUM_BITS-1:0] i_o,
    output logic [NUM_CH*2*NUM_BITS-1:0] q_o,
    output logic                         valid_o,
    output logic                         busy_o,
    output logic                         overrun_o
);

    localparam int PW  = 2 * NUM_BITS;
    localparam int AW  = PW + DECIM_LOG2;
    localparam int KW  = $clog2(2 * NUM_CH + 1);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(2 * NUM_CH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << DECIM_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, MAC, DUMP} state_t;

    state_t                      state;
    logic [KW-1:0]               k;
    logic [CW-1:0]               cnt;
    logic                        win_done;
    logic [NUM_CH*NUM_BITS-1:0]  sig_r;
    logic [NUM_BITS-1:0]         sin_r;
    logic [NUM_BITS-1:0]         cos_r;
    logic signed [AW-1:0]        acc_i [NUM_CH];
    logic signed [AW-1:0]        acc_q [NUM_CH];

    logic [CHW-1:0]              ch_idx;
    logic signed [NUM_BITS-1:0]  mul_a;
    logic signed [NUM_BITS-1:0]  mul_b;
    logic signed [PW-1:0]        prod;
    logic signed [AW-1:0]        prod_ext;

    always_comb begin
        ch_idx   = CHW'(k >> 1);
        mul_a    = sig_r[ch_idx*NUM_BITS +: NUM_BITS];
        mul_b    = k[0] ? cos_r : sin_r;
        // (-2^(N-1))^2 still fits in 2N signed bits, so the product is exact
        prod     = PW'(mul_a) * PW'(mul_b);
        prod_ext = AW'(prod);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            k         <= '0;
            cnt       <= '0;
            win_done  <= 1'b0;
            sig_r     <= '0;
            sin_r     <= '0;
            cos_r     <= '0;
            i_o       <= '0;
            q_o       <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_i[c] <= '0;
                acc_q[c] <= '0;
            end
        end else if (clear_i) begin
            state    <= IDLE;
            k        <= '0;
            cnt      <= '0;
            win_done <= 1'b0;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_i[c] <= '0;
                acc_q[c] <= '0;
            end
        end else begin
            valid_o <= 1'b0;
            if (tick_i && state != IDLE) begin
                overrun_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick_i) begin
                        sig_r    <= sig_i;
                        sin_r    <= sin_i;
                        cos_r    <= cos_i;
                        k        <= '0;
                        win_done <= (cnt == CNT_LAST);
                        cnt      <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                        state    <= MAC;
                        busy_o   <= 1'b1;
                    end
                end
                MAC: begin
                    if (k[0]) begin
                        acc_q[ch_idx] <= acc_q[ch_idx] + prod_ext;
                    end else begin
                        acc_i[ch_idx] <= acc_i[ch_idx] + prod_ext;
                    end
                    if (k == K_LAST) begin
                        state  <= win_done ? DUMP : IDLE;
                        busy_o <= win_done;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DUMP: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        i_o[c*PW +: PW] <= PW'(acc_i[c] >>> DECIM_LOG2);
                        q_o[c*PW +: PW] <= PW'(acc_q[c] >>> DECIM_LOG2);
                        acc_i[c]        <= '0;
                        acc_q[c]        <= '0;
                    end
                    valid_o <= 1'b1;
                    state   <= IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lockin_demodulator.sv
// Directed bench for lockin_demodulator: a 2-channel, 4-tick-window instance plus a
// DECIM_LOG2=0 instance, with hand-computed window means.
module tb_lockin_demodulator;

    localparam longint M23 = 64'sd8388608;

    logic        clk, rst, tick, tick0, clr;
    logic [47:0] sig;
    logic [23:0] sn, cs;
    logic [95:0] i_d, q_d, i_0, q_0;
    logic        valid, busy, ovr;
    logic        valid0, busy0, ovr0;

    int n_cmp = 0;
    int n_err = 0;

    lockin_demodulator #(.NUM_BITS(24), .NUM_CH(2), .DECIM_LOG2(2)) dut (
        .clk_i(clk), .reset_i(rst), .tick_i(tick), .clear_i(clr),
        .sig_i(sig), .sin_i(sn), .cos_i(cs),
        .i_o(i_d), .q_o(q_d), .valid_o(valid), .busy_o(busy), .overrun_o(ovr)
    );

    lockin_demodulator #(.NUM_BITS(24), .NUM_CH(2), .DECIM_LOG2(0)) dut0 (
        .clk_i(clk), .reset_i(rst), .tick_i(tick0), .clear_i(clr),
        .sig_i(sig), .sin_i(sn), .cos_i(cs),
        .i_o(i_0), .q_o(q_0), .valid_o(valid0), .busy_o(busy0), .overrun_o(ovr0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input logic [95:0] v, input int c);
        logic signed [47:0] t;
        t = v[c*48 +: 48];
        return longint'(t);
    endfunction

    task automatic set_in(input longint c0, input longint c1, input longint s, input longint c);
        sig = {24'(c1), 24'(c0)};
        sn  = 24'(s);
        cs  = 24'(c);
    endtask

    // One tick, then 7 idle cycles: reports the cycle (after the tick edge) at which
    // valid appeared (0 = none) and how many cycles it stayed high.
    task automatic send_tick(input bit sel, input int exp_lat, input string tag);
        int lat;
        int hits;
        @(negedge clk);
        if (sel) tick0 = 1'b1; else tick = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
        tick0 = 1'b0;
        lat   = 0;
        hits  = 0;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (j == 1) chk({tag, "_busy_hi"}, longint'(sel ? busy0 : busy), 1);
            if (j == 7) chk({tag, "_busy_lo"}, longint'(sel ? busy0 : busy), 0);
            if (sel ? valid0 : valid) begin
                hits++;
                if (lat == 0) lat = j;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_hits"}, hits, (exp_lat != 0) ? 1 : 0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; tick0 = 1'b0; clr = 1'b0;
        set_in(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_i0", lane(i_d, 0), 0);
        chk("rst_q1", lane(q_d, 1), 0);
        chk("rst_valid", longint'(valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ovr", longint'(ovr), 0);
        rst = 1'b0;

        // basic window: 100*1000 per tick on ch0, -100*1000 on ch1
        set_in(100, -100, 1000, 0);
        for (int t = 0; t < 3; t++) send_tick(0, 0, "basic");
        send_tick(0, 5, "basic_last");
        chk("basic_i0", lane(i_d, 0), 100000);
        chk("basic_i1", lane(i_d, 1), -100000);
        chk("basic_q0", lane(q_d, 0), 0);
        chk("basic_q1", lane(q_d, 1), 0);

        // extremes: (-2^23)^2 and -2^23*(2^23-1), summed 4x then /4
        set_in(-M23, 0, -M23, M23 - 1);
        for (int t = 0; t < 3; t++) send_tick(0, 0, "ext");
        send_tick(0, 5, "ext_last");
        chk("ext_i0", lane(i_d, 0), M23 * M23);
        chk("ext_q0", lane(q_d, 0), -(M23 * M23) + M23);
        chk("ext_i1", lane(i_d, 1), 0);

        // floor rounding: sum -1 -> -1, sum 3 -> 0
        set_in(-1, 0, 1, 0);
        send_tick(0, 0, "flr_a");
        chk("hold_i0", lane(i_d, 0), M23 * M23);
        set_in(0, 0, 1, 0);
        send_tick(0, 0, "flr_a");
        send_tick(0, 0, "flr_a");
        send_tick(0, 5, "flr_a_last");
        chk("flr_neg_i0", lane(i_d, 0), -1);
        set_in(3, 0, 1, 0);
        send_tick(0, 0, "flr_b");
        set_in(0, 0, 1, 0);
        send_tick(0, 0, "flr_b");
        send_tick(0, 0, "flr_b");
        send_tick(0, 5, "flr_b_last");
        chk("flr_pos_i0", lane(i_d, 0), 0);

        // overrun: second tick 2 cycles after the first carries different data and must be dropped;
        // the window then completes on the 4th legal tick (first + 3 more)
        set_in(5, 0, 2, 0);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk); tick = 1'b1; set_in(99, 0, 2, 0);
        @(negedge clk); tick = 1'b0; set_in(5, 0, 2, 0);
        chk("ovr_set", longint'(ovr), 1);
        repeat (6) @(negedge clk);
        send_tick(0, 0, "ovr");
        send_tick(0, 0, "ovr");
        send_tick(0, 5, "ovr_last");
        chk("ovr_i0", lane(i_d, 0), 10);
        chk("ovr_held", longint'(ovr), 1);

        // clear after 2 ticks, together with a tick that must be ignored
        set_in(1000, 0, 1000, 0);
        send_tick(0, 0, "clr_pre");
        send_tick(0, 0, "clr_pre");
        @(negedge clk); clr = 1'b1; tick = 1'b1;
        @(negedge clk); clr = 1'b0; tick = 1'b0;
        chk("clr_keep_i0", lane(i_d, 0), 10);
        chk("clr_keep_ovr", longint'(ovr), 1);
        chk("clr_busy", longint'(busy), 0);
        set_in(9, -3, -2, 1);
        for (int t = 0; t < 3; t++) send_tick(0, 0, "clr");
        send_tick(0, 5, "clr_last");
        chk("clr_i0", lane(i_d, 0), -18);
        chk("clr_q0", lane(q_d, 0), 9);
        chk("clr_i1", lane(i_d, 1), 6);
        chk("clr_q1", lane(q_d, 1), -3);

        // reset mid-MAC takes effect without a clock edge
        set_in(1000, 0, 1000, 0);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1;
        chk("arst_busy", longint'(busy), 0);
        chk("arst_i0", lane(i_d, 0), 0);
        chk("arst_q0", lane(q_d, 0), 0);
        chk("arst_ovr", longint'(ovr), 0);
        @(negedge clk); rst = 1'b0;
        set_in(-7, 4, 3, 2);
        for (int t = 0; t < 3; t++) send_tick(0, 0, "arst");
        send_tick(0, 5, "arst_last");
        chk("arst_i0_win", lane(i_d, 0), -21);
        chk("arst_q0_win", lane(q_d, 0), -14);
        chk("arst_i1_win", lane(i_d, 1), 12);
        chk("arst_q1_win", lane(q_d, 1), 8);

        // DECIM_LOG2=0: every tick dumps the raw products
        set_in(0, 7, 0, -3);
        send_tick(1, 5, "d0");
        chk("d0_q1", lane(q_0, 1), -21);
        chk("d0_i1", lane(i_0, 1), 0);
        chk("d0_q0", lane(q_0, 0), 0);
        chk("d0_ovr", longint'(ovr0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
